lsu_mem_ctrl: RTL

Load/store controller between the EX/MEM pipeline register and the word-addressed data memory (`data_mem`). Takes byte-addressed load/store requests of byte, halfword or word size, drives the memory's word address, write data, write enable and read enable, and returns aligned, sign- or zero-extended load data to the MEM/WB register. Sub-word stores use a two-cycle read-modify-write sequence, and the controller stalls the pipeline for that extra cycle. Misaligned and out-of-range accesses are blocked and flagged.

---
 rtl/lsu_mem_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between EX/MEM and a word-addressed data memory.
// Sub-word stores run as a read cycle followed by a write cycle of the merged word.
module lsu_mem_ctrl #(
    parameter int N     = 32,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    output logic [N-1:0] resp_rdata,
    output logic         resp_err,
    output logic [N-1:0] mem_address,
    output logic [N-1:0] mem_data_in,
    input  logic [N-1:0] mem_data_out,
    output logic         mem_we,
    output logic         mem_read
);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    localparam logic [1:0]   SZ_B    = 2'b00;
    localparam logic [1:0]   SZ_H    = 2'b01;
    localparam logic [1:0]   SZ_W    = 2'b10;
    localparam logic [1:0]   SZ_BAD  = 2'b11;
    localparam logic [N-1:0] DEPTH_L = N'(DEPTH);

    state_t       state_q;
    logic [N-1:0] merge_q;
    logic [N-1:0] idx_q;
    logic [N-1:0] rdata_q;
    logic         valid_q;
    logic         err_q;

    logic         accept;
    logic         addr_err;
    logic         word_st;
    logic [N-1:0] word_idx;

    function automatic logic [N-1:0] load_extend(input logic [N-1:0] word,
                                                 input logic [1:0]   off,
                                                 input logic [1:0]   size,
                                                 input logic         uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    load_extend = uns ? {{(N-8){1'b0}}, b} : {{(N-8){b[7]}}, b};
            SZ_H:    load_extend = uns ? {{(N-16){1'b0}}, h} : {{(N-16){h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    function automatic logic [N-1:0] merge_lane(input logic [N-1:0] word,
                                                input logic [N-1:0] wdata,
                                                input logic [1:0]   off,
                                                input logic [1:0]   size);
        logic [N-1:0] m;
        m = word;
        if (size == SZ_B)
            m[{off, 3'b000} +: 8] = wdata[7:0];
        else
            m[{off[1], 4'b0000} +: 16] = wdata[15:0];
        return m;
    endfunction

    assign word_idx  = {2'b00, req_addr[N-1:2]};
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign word_st   = req_we && (req_size == SZ_W);
    assign addr_err  = (req_size == SZ_BAD)
                    || ((req_size == SZ_H) && req_addr[0])
                    || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00))
                    || (word_idx >= DEPTH_L);

    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Memory strobes are combinational so the falling-edge write lands in the same cycle.
    always_comb begin
        mem_we      = 1'b0;
        mem_read    = 1'b0;
        mem_address = word_idx;
        mem_data_in = '0;
        if (state_q == WRITE) begin
            mem_we      = 1'b1;
            mem_address = idx_q;
            mem_data_in = merge_q;
        end else if (accept && !addr_err) begin
            if (word_st) begin
                mem_we      = 1'b1;
                mem_data_in = req_wdata;
            end else begin
                mem_read = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            merge_q <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (addr_err) begin
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (!req_we) begin
                            valid_q <= 1'b1;
                            rdata_q <= load_extend(mem_data_out, req_addr[1:0], req_size, req_unsigned);
                        end else if (word_st) begin
                            valid_q <= 1'b1;
                        end else begin
                            idx_q   <= word_idx;
                            merge_q <= merge_lane(mem_data_out, req_wdata, req_addr[1:0], req_size);
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                    valid_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
